// File: rtl/frame_line_packer_pkg.sv
// Types and command codes shared by the line packer and the frame uploader.
package frame_packer_types;

    typedef enum logic [2:0] {
        StWaitFrame,
        StRowActive,
        StRowDrop,
        StRowCommit,
        StNextRow,
        StFrameEnd
    } t_state;

    localparam logic [1:0] CMD_FRAME_START = 2'd1;
    localparam logic [1:0] CMD_ROW_READY   = 2'd2;
    localparam logic [1:0] CMD_FRAME_END   = 2'd3;

endpackage

// File: rtl/frame_line_packer_if.sv
// Camera stream, line buffer write port, bank handshake and command queue of the line packer.
interface frame_line_packer_if;

    logic        cam_frame_start;
    logic        cam_pixel_valid;
    logic [15:0] cam_pixel;
    logic        lb_wr_en;
    logic [10:0] lb_wr_addr;
    logic [31:0] lb_wr_data;
    logic        rd_bank;
    logic        line_release;
    logic        command_data_valid;
    logic [1:0]  command_data;
    logic        read_rdy;
    logic        overflow;
    logic        frame_error;

    modport master (
        input  cam_frame_start, cam_pixel_valid, cam_pixel, line_release, read_rdy,
        output lb_wr_en, lb_wr_addr, lb_wr_data, rd_bank, command_data_valid, command_data,
               overflow, frame_error
    );

    modport slave (
        output cam_frame_start, cam_pixel_valid, cam_pixel, line_release, read_rdy,
        input  lb_wr_en, lb_wr_addr, lb_wr_data, rd_bank, command_data_valid, command_data,
               overflow, frame_error
    );

endinterface

// File: rtl/frame_line_packer_cmd_fifo.sv
// First-word-fall-through command FIFO; a pop in the same cycle frees the slot for a push.
module cmd_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PtrW+1)'(Depth));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/frame_line_packer.sv
// Packs RGB565 pixel pairs into a double-banked line buffer and queues frame/row commands
// for the uploader, holding each committed bank until the uploader releases it.
module frame_line_packer
    import frame_packer_types::*;
#(
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned CMD_DEPTH    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    frame_line_packer_if.master bus
);

    localparam int unsigned RowW    = $clog2(FRAME_HEIGHT + 1);
    localparam logic [10:0] LastCol = 11'(FRAME_WIDTH - 1);

    t_state          state_q;
    logic [10:0]     col_q;
    logic [RowW-1:0] row_q;
    logic [15:0]     lo_pix_q;
    logic            wr_bank_q, rd_bank_q;
    logic [1:0]      bank_busy_q, bank_busy_d;
    logic            overflow_q, frame_error_q;
    logic            lb_wr_en_q;
    logic [10:0]     lb_wr_addr_q;
    logic [31:0]     lb_wr_data_q;

    logic            push_en, push_ok, commit_ok, release_ok;
    logic [1:0]      push_cmd, fifo_data;
    logic            fifo_full, fifo_empty;
    logic [RowW-1:0] row_inc;

    assign row_inc = row_q + RowW'(1);

    always_comb begin
        push_en  = 1'b0;
        push_cmd = CMD_FRAME_START;
        if (bus.cam_frame_start) begin
            push_en = 1'b1;
        end else if (state_q == StRowCommit) begin
            push_en  = 1'b1;
            push_cmd = CMD_ROW_READY;
        end else if (state_q == StFrameEnd) begin
            push_en  = 1'b1;
            push_cmd = CMD_FRAME_END;
        end
        // A full FIFO still accepts the push when the uploader pops in the same cycle.
        push_ok    = !fifo_full || bus.read_rdy;
        commit_ok  = !bus.cam_frame_start && (state_q == StRowCommit) && push_ok;
        release_ok = bus.line_release && bank_busy_q[rd_bank_q];

        bank_busy_d = bank_busy_q;
        if (release_ok) begin
            bank_busy_d[rd_bank_q] = 1'b0;
        end
        if (commit_ok) begin
            bank_busy_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_busy_q <= 2'b00;
            rd_bank_q   <= 1'b0;
        end else begin
            bank_busy_q <= bank_busy_d;
            if (release_ok) begin
                rd_bank_q <= !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StWaitFrame;
            col_q         <= '0;
            row_q         <= '0;
            lo_pix_q      <= '0;
            wr_bank_q     <= 1'b0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
            lb_wr_en_q    <= 1'b0;
            lb_wr_addr_q  <= '0;
            lb_wr_data_q  <= '0;
        end else begin
            lb_wr_en_q <= 1'b0;
            if (bus.cam_frame_start) begin
                // Any partial row is abandoned; committed banks keep their busy state.
                col_q <= '0;
                row_q <= '0;
                if (state_q != StWaitFrame) begin
                    frame_error_q <= 1'b1;
                end
                if (push_ok) begin
                    state_q <= StRowActive;
                end else begin
                    overflow_q <= 1'b1;
                    state_q    <= StWaitFrame;
                end
            end else begin
                case (state_q)
                    StWaitFrame: ;
                    StRowActive: begin
                        if (bus.cam_pixel_valid) begin
                            if (col_q == '0 && bank_busy_q[wr_bank_q]) begin
                                overflow_q <= 1'b1;
                                col_q      <= col_q + 11'd1;
                                state_q    <= StRowDrop;
                            end else begin
                                if (!col_q[0]) begin
                                    lo_pix_q <= bus.cam_pixel;
                                end else begin
                                    lb_wr_en_q   <= 1'b1;
                                    lb_wr_addr_q <= {wr_bank_q, col_q[10:1]};
                                    lb_wr_data_q <= {bus.cam_pixel, lo_pix_q};
                                end
                                if (col_q == LastCol) begin
                                    col_q   <= '0;
                                    state_q <= StRowCommit;
                                end else begin
                                    col_q <= col_q + 11'd1;
                                end
                            end
                        end
                    end
                    StRowDrop: begin
                        if (bus.cam_pixel_valid) begin
                            if (col_q == LastCol) begin
                                col_q   <= '0;
                                state_q <= StNextRow;
                            end else begin
                                col_q <= col_q + 11'd1;
                            end
                        end
                    end
                    StRowCommit: begin
                        // Without room for the command the row is dropped and its bank reused.
                        if (push_ok) begin
                            wr_bank_q <= !wr_bank_q;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        state_q <= StNextRow;
                    end
                    StNextRow: begin
                        row_q <= row_inc;
                        col_q <= '0;
                        if (row_inc == RowW'(FRAME_HEIGHT)) begin
                            state_q <= StFrameEnd;
                        end else begin
                            state_q <= StRowActive;
                        end
                    end
                    StFrameEnd: begin
                        if (push_ok) begin
                            state_q <= StWaitFrame;
                        end
                    end
                    default: state_q <= StWaitFrame;
                endcase
            end
        end
    end

    cmd_fifo #(
        .Width (2),
        .Depth (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_en && push_ok),
        .push_data (push_cmd),
        .pop       (bus.read_rdy),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.lb_wr_en           = lb_wr_en_q;
    assign bus.lb_wr_addr         = lb_wr_addr_q;
    assign bus.lb_wr_data         = lb_wr_data_q;
    assign bus.rd_bank            = rd_bank_q;
    assign bus.command_data_valid = !fifo_empty;
    assign bus.command_data       = fifo_empty ? 2'b00 : fifo_data;
    assign bus.overflow           = overflow_q;
    assign bus.frame_error        = frame_error_q;

endmodule

// File: tb/tb_frame_line_packer.sv
// Scoreboard bench for frame_line_packer: 4x2 frames with a 2-deep command FIFO.
module tb_frame_line_packer;
    import frame_packer_types::*;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;
    localparam int unsigned D = 2;

    logic clk = 1'b0;
    logic reset_n;

    frame_line_packer_if bus ();

    frame_line_packer #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .CMD_DEPTH    (D)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [42:0] exp_wr [$];
    logic [1:0]  exp_cmd [$];
    logic [42:0] e_wr;
    logic [1:0]  e_cmd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares every write and every popped command against the queues.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.lb_wr_en) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want none",
                             bus.lb_wr_addr, bus.lb_wr_data);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.lb_wr_addr), 32'(e_wr[42:32]));
                    check("wr_data", bus.lb_wr_data, e_wr[31:0]);
                end
            end
            if (bus.command_data_valid && bus.read_rdy) begin
                if (exp_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got %0d, want none", bus.command_data);
                end else begin
                    e_cmd = exp_cmd.pop_front();
                    check("cmd", 32'(bus.command_data), 32'(e_cmd));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pixel(input logic [15:0] p);
        bus.cam_pixel       = p;
        bus.cam_pixel_valid = 1'b1;
        tick();
        bus.cam_pixel_valid = 1'b0;
    endtask

    task automatic start_frame();
        bus.cam_frame_start = 1'b1;
        tick();
        bus.cam_frame_start = 1'b0;
    endtask

    task automatic release_line();
        bus.line_release = 1'b1;
        tick();
        bus.line_release = 1'b0;
    endtask

    // Pixel k is 0x1111*k; expected writes are queued before the odd pixel is driven.
    task automatic send_row(input int first, input int gap, input logic bank, input bit wr);
        logic [15:0] lo, p;
        lo = '0;
        for (int c = 0; c < int'(W); c++) begin
            p = 16'(32'h1111 * (first + c));
            if (c % 2 == 0) lo = p;
            else if (wr) exp_wr.push_back({bank, 10'(c / 2), p, lo});
            pixel(p);
            idle(gap);
        end
        idle(4);
    endtask

    task automatic frame_body(input int gap);
        exp_cmd.push_back(CMD_ROW_READY);
        send_row(1, gap, 1'b0, 1'b1);
        release_line();
        exp_cmd.push_back(CMD_ROW_READY);
        exp_cmd.push_back(CMD_FRAME_END);
        send_row(5, gap, 1'b1, 1'b1);
        release_line();
        idle(4);
    endtask

    task automatic frame_released(input int gap);
        exp_cmd.push_back(CMD_FRAME_START);
        start_frame();
        idle(2);
        frame_body(gap);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic queues_drained();
        idle(6);
        check("wr_left", 32'(exp_wr.size()), 0);
        check("cmd_left", 32'(exp_cmd.size()), 0);
    endtask

    task automatic check_outputs_zero();
        check("rst_wr_en", 32'(bus.lb_wr_en), 0);
        check("rst_wr_addr", 32'(bus.lb_wr_addr), 0);
        check("rst_wr_data", bus.lb_wr_data, 0);
        check("rst_rd_bank", 32'(bus.rd_bank), 0);
        check("rst_cmd_valid", 32'(bus.command_data_valid), 0);
        check("rst_cmd_data", 32'(bus.command_data), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_frame_error", 32'(bus.frame_error), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        reset_n             = 1'b1;
        bus.cam_frame_start = 1'b0;
        bus.cam_pixel_valid = 1'b0;
        bus.cam_pixel       = '0;
        bus.line_release    = 1'b0;
        bus.read_rdy        = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_outputs_zero();
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // Basic frame, each row released after commit.
        bus.read_rdy = 1'b1;
        frame_released(0);
        check("s1_overflow", 32'(bus.overflow), 0);
        check("s1_frame_error", 32'(bus.frame_error), 0);
        check("s1_rd_bank", 32'(bus.rd_bank), 0);
        queues_drained();

        // Idle cycles between pixels.
        do_reset();
        frame_released(2);
        check("s3_overflow", 32'(bus.overflow), 0);
        queues_drained();

        // No releases: second frame finds both banks busy and drops both rows.
        do_reset();
        exp_cmd.push_back(CMD_FRAME_START);
        start_frame();
        idle(2);
        exp_cmd.push_back(CMD_ROW_READY);
        send_row(1, 0, 1'b0, 1'b1);
        exp_cmd.push_back(CMD_ROW_READY);
        exp_cmd.push_back(CMD_FRAME_END);
        send_row(5, 0, 1'b1, 1'b1);
        check("s2_no_overflow_yet", 32'(bus.overflow), 0);
        exp_cmd.push_back(CMD_FRAME_START);
        start_frame();
        idle(2);
        send_row(1, 0, 1'b0, 1'b0);
        exp_cmd.push_back(CMD_FRAME_END);
        send_row(5, 0, 1'b0, 1'b0);
        check("s2_overflow", 32'(bus.overflow), 1);
        check("s2_frame_error", 32'(bus.frame_error), 0);
        check("s2_rd_bank0", 32'(bus.rd_bank), 0);
        release_line();
        check("s2_rd_bank1", 32'(bus.rd_bank), 1);
        release_line();
        check("s2_rd_bank2", 32'(bus.rd_bank), 0);
        release_line();
        check("s2_release_ignored", 32'(bus.rd_bank), 0);
        queues_drained();

        // Restart after three pixels of row 0.
        do_reset();
        exp_cmd.push_back(CMD_FRAME_START);
        start_frame();
        idle(2);
        pixel(16'hAAAA);
        exp_wr.push_back({1'b0, 10'd0, 16'hBBBB, 16'hAAAA});
        pixel(16'hBBBB);
        pixel(16'hCCCC);
        idle(2);
        check("s4_no_error_yet", 32'(bus.frame_error), 0);
        exp_cmd.push_back(CMD_FRAME_START);
        start_frame();
        check("s4_frame_error", 32'(bus.frame_error), 1);
        idle(2);
        frame_body(0);
        check("s4_overflow", 32'(bus.overflow), 0);
        queues_drained();

        // Consumer stalled: second commit lost, frame end waits for a pop.
        do_reset();
        bus.read_rdy = 1'b0;
        exp_cmd.push_back(CMD_FRAME_START);
        exp_cmd.push_back(CMD_ROW_READY);
        exp_cmd.push_back(CMD_FRAME_END);
        start_frame();
        idle(2);
        send_row(1, 0, 1'b0, 1'b1);
        send_row(5, 0, 1'b1, 1'b1);
        idle(4);
        check("s5_overflow", 32'(bus.overflow), 1);
        check("s5_cmd_valid", 32'(bus.command_data_valid), 1);
        check("s5_head", 32'(bus.command_data), 32'(CMD_FRAME_START));
        bus.read_rdy = 1'b1;
        tick();
        bus.read_rdy = 1'b0;
        idle(2);
        check("s5_head_after_pop", 32'(bus.command_data), 32'(CMD_ROW_READY));
        bus.read_rdy = 1'b1;
        queues_drained();
        check("s5_empty", 32'(bus.command_data_valid), 0);

        // Reset in the middle of a row with a write in flight.
        bus.read_rdy = 1'b0;
        start_frame();
        pixel(16'h1111);
        start_frame();
        pixel(16'h1111);
        pixel(16'h2222);
        check("s6_wr_in_flight", 32'(bus.lb_wr_en), 1);
        check("s6_error_before", 32'(bus.frame_error), 1);
        reset_n = 1'b0;
        #1 check_outputs_zero();
        idle(2);
        reset_n = 1'b1;
        idle(1);
        check("s6_cmd_valid", 32'(bus.command_data_valid), 0);
        bus.read_rdy = 1'b1;
        frame_released(0);
        check("s6_overflow", 32'(bus.overflow), 0);
        queues_drained();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
